// File: rtl/c2h_mm_marker_ctl.sv
// C2H MM bypass marker controller: waits for a quiet MM path, issues a marker
// request, then times the returned response and reports status.
module c2h_mm_marker_ctl #(
  parameter int TIMEOUT_CYC = 65535,
  parameter int LAT_W       = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic             marker_start,
  input  logic [1:0]       c2h_dsc_bypass,
  input  logic             c2h_byp_out_vld,
  input  logic             c2h_byp_out_st_mm,
  input  logic             c2h_byp_in_mm_rdy,
  input  logic             c2h_mm_marker_rsp,
  output logic             c2h_mm_marker_req,
  output logic             marker_busy,
  output logic             marker_done,
  output logic             marker_timeout,
  output logic             marker_reject,
  output logic [LAT_W-1:0] marker_lat
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_QUIET = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            path_quiet;
  logic            start_ok;
  logic            accept;
  logic            to_hit;

  assign path_quiet = ~(c2h_byp_out_vld & c2h_byp_out_st_mm);
  assign start_ok   = marker_start & (state == S_IDLE) & (c2h_dsc_bypass == 2'b01);
  assign accept     = c2h_mm_marker_req & c2h_byp_in_mm_rdy;
  assign to_hit     = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_QUIET;
      S_QUIET: if (path_quiet) state_nxt = S_REQ;
      S_REQ:   if (accept) state_nxt = S_WAIT;
      // A response arriving on the timeout cycle still counts as success.
      S_WAIT: begin
        if (c2h_mm_marker_rsp) state_nxt = S_DONE;
        else if (to_hit)       state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state             <= S_IDLE;
      to_cnt            <= '0;
      c2h_mm_marker_req <= 1'b0;
      marker_busy       <= 1'b0;
      marker_done       <= 1'b0;
      marker_timeout    <= 1'b0;
      marker_reject     <= 1'b0;
      marker_lat        <= '0;
    end else begin
      state             <= state_nxt;
      c2h_mm_marker_req <= (state_nxt == S_REQ);
      marker_busy       <= (state_nxt != S_IDLE);
      marker_done       <= (state == S_DONE);
      marker_reject     <= marker_start & ~start_ok;

      if ((state == S_WAIT) && (state_nxt == S_WAIT))
        to_cnt <= to_cnt + TO_W'(1);
      else
        to_cnt <= '0;

      if (start_ok)
        marker_timeout <= 1'b0;
      else if ((state == S_WAIT) && !c2h_mm_marker_rsp && to_hit)
        marker_timeout <= 1'b1;

      // Latency includes the response cycle and saturates rather than wrapping.
      if (start_ok)
        marker_lat <= '0;
      else if ((state == S_WAIT) && (marker_lat != {LAT_W{1'b1}}))
        marker_lat <= marker_lat + LAT_W'(1);
    end
  end

endmodule

// File: tb/tb_c2h_mm_marker_ctl.sv
// Directed bench for c2h_mm_marker_ctl: a table of one-cycle vectors followed
// by hand-written multi-cycle sequences (backpressure, gating, timeout, reset).
module tb_c2h_mm_marker_ctl;

  logic        clk;
  logic        aresetn;
  logic        start;
  logic [1:0]  mode;
  logic        vld;
  logic        st_mm;
  logic        rdy;
  logic        rsp;
  logic        req;
  logic        busy;
  logic        done;
  logic        tmo;
  logic        rej;
  logic [15:0] lat;
  logic [20:0] obs;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic        start;
    logic [1:0]  mode;
    logic        vld;
    logic        st_mm;
    logic        rdy;
    logic        rsp;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[17];

  c2h_mm_marker_ctl #(.TIMEOUT_CYC(8), .LAT_W(16)) dut (
    .axi_aclk          (clk),
    .axi_aresetn       (aresetn),
    .marker_start      (start),
    .c2h_dsc_bypass    (mode),
    .c2h_byp_out_vld   (vld),
    .c2h_byp_out_st_mm (st_mm),
    .c2h_byp_in_mm_rdy (rdy),
    .c2h_mm_marker_rsp (rsp),
    .c2h_mm_marker_req (req),
    .marker_busy       (busy),
    .marker_done       (done),
    .marker_timeout    (tmo),
    .marker_reject     (rej),
    .marker_lat        (lat)
  );

  assign obs = {req, busy, done, rej, tmo, lat};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] pk(logic q, logic b, logic d, logic r, logic t,
                                     logic [15:0] l);
    return {q, b, d, r, t, l};
  endfunction

  function automatic vec_t mk(logic s, logic [1:0] m, logic v, logic st, logic rd,
                              logic rs, logic [20:0] e);
    vec_t x;
    x.start = s; x.mode = m; x.vld = v; x.st_mm = st; x.rdy = rd; x.rsp = rs; x.exp = e;
    return x;
  endfunction

  // Drive one cycle of inputs, let one rising edge pass, return on the falling edge.
  task automatic applyStimulus(input logic s, input logic [1:0] m, input logic v,
                               input logic st, input logic rd, input logic rs);
    start = s; mode = m; vld = v; st_mm = st; rdy = rd; rsp = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [20:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got req/busy/done/rej/tmo/lat=%h expected %h",
                  name, obs, exp);
  endtask

  initial begin
    vecs[0]  = mk(1, 2'b01, 0, 0, 1, 0, pk(0, 1, 0, 0, 0, 0));
    vecs[1]  = mk(0, 2'b01, 0, 0, 1, 0, pk(1, 1, 0, 0, 0, 0));
    vecs[2]  = mk(0, 2'b01, 0, 0, 1, 0, pk(0, 1, 0, 0, 0, 0));
    vecs[3]  = mk(0, 2'b01, 0, 0, 1, 0, pk(0, 1, 0, 0, 0, 1));
    vecs[4]  = mk(0, 2'b01, 0, 0, 1, 0, pk(0, 1, 0, 0, 0, 2));
    vecs[5]  = mk(0, 2'b01, 0, 0, 1, 1, pk(0, 1, 0, 0, 0, 3));
    vecs[6]  = mk(0, 2'b01, 0, 0, 1, 0, pk(0, 0, 1, 0, 0, 3));
    vecs[7]  = mk(0, 2'b01, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 3));
    vecs[8]  = mk(1, 2'b10, 0, 0, 1, 0, pk(0, 0, 0, 1, 0, 3));
    vecs[9]  = mk(0, 2'b10, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 3));
    vecs[10] = mk(1, 2'b01, 0, 0, 0, 0, pk(0, 1, 0, 0, 0, 0));
    vecs[11] = mk(1, 2'b01, 0, 0, 0, 0, pk(1, 1, 0, 1, 0, 0));
    vecs[12] = mk(0, 2'b01, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0));
    vecs[13] = mk(0, 2'b01, 0, 0, 1, 0, pk(0, 1, 0, 0, 0, 0));
    vecs[14] = mk(0, 2'b01, 0, 0, 0, 1, pk(0, 1, 0, 0, 0, 1));
    vecs[15] = mk(0, 2'b01, 0, 0, 0, 1, pk(0, 0, 1, 0, 0, 1));
    vecs[16] = mk(0, 2'b01, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));

    aresetn = 1'b0;
    applyStimulus(0, 2'b01, 0, 0, 0, 0);
    applyStimulus(1, 2'b01, 0, 0, 1, 1);
    checkOutput("reset", pk(0, 0, 0, 0, 0, 0));
    aresetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].start, vecs[i].mode, vecs[i].vld, vecs[i].st_mm,
                    vecs[i].rdy, vecs[i].rsp);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Backpressure: req held through five rdy=0 cycles, latency starts at acceptance.
    applyStimulus(1, 2'b01, 0, 0, 0, 0);
    checkOutput("bp_quiet", pk(0, 1, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 0, 0, 0, 0);
    checkOutput("bp_req_rise", pk(1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 2'b01, 0, 0, 0, 0);
      checkOutput($sformatf("bp_hold%0d", i), pk(1, 1, 0, 0, 0, 0));
    end
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    checkOutput("bp_accept", pk(0, 1, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 0, 0, 1, 1);
    checkOutput("bp_rsp", pk(0, 1, 0, 0, 0, 1));
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    checkOutput("bp_done", pk(0, 0, 1, 0, 0, 1));

    // Quiet gating: MM descriptors hold off req; a non-MM descriptor does not.
    applyStimulus(1, 2'b01, 1, 1, 0, 0);
    checkOutput("qg_busy0", pk(0, 1, 0, 0, 0, 0));
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 2'b01, 1, 1, 0, 0);
      checkOutput($sformatf("qg_busy%0d", i), pk(0, 1, 0, 0, 0, 0));
    end
    applyStimulus(0, 2'b01, 1, 0, 0, 0);
    checkOutput("qg_req", pk(1, 1, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 1, 1, 0, 0);
    checkOutput("qg_req_keep", pk(1, 1, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 1, 1, 1, 0);
    checkOutput("qg_accept", pk(0, 1, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 0, 0, 0, 1);
    checkOutput("qg_rsp", pk(0, 1, 0, 0, 0, 1));
    applyStimulus(0, 2'b01, 0, 0, 0, 0);
    checkOutput("qg_done", pk(0, 0, 1, 0, 0, 1));

    // Timeout after 8 WAIT_RSP cycles with no response.
    applyStimulus(1, 2'b01, 0, 0, 1, 0);
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    checkOutput("to_wait", pk(0, 1, 0, 0, 0, 0));
    for (int i = 1; i < 8; i++) begin
      applyStimulus(0, 2'b01, 0, 0, 1, 0);
      checkOutput($sformatf("to_lat%0d", i), pk(0, 1, 0, 0, 0, 16'(i)));
    end
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    checkOutput("to_fire", pk(0, 0, 0, 0, 1, 8));
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    checkOutput("to_no_done", pk(0, 0, 0, 0, 1, 8));
    applyStimulus(0, 2'b01, 0, 0, 1, 1);
    checkOutput("to_stray_rsp", pk(0, 0, 0, 0, 1, 8));

    // Next start clears the sticky flag; response on the timeout cycle wins.
    applyStimulus(1, 2'b01, 0, 0, 1, 0);
    checkOutput("to_clear", pk(0, 1, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    for (int i = 1; i < 8; i++) applyStimulus(0, 2'b01, 0, 0, 1, 0);
    applyStimulus(0, 2'b01, 0, 0, 1, 1);
    checkOutput("race_rsp", pk(0, 1, 0, 0, 0, 8));
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    checkOutput("race_done", pk(0, 0, 1, 0, 0, 8));

    // Reset clears held latency in IDLE, then aborts a pending request.
    aresetn = 1'b0;
    applyStimulus(0, 2'b01, 0, 0, 0, 0);
    checkOutput("rst_idle", pk(0, 0, 0, 0, 0, 0));
    aresetn = 1'b1;
    applyStimulus(1, 2'b01, 0, 0, 0, 0);
    applyStimulus(0, 2'b01, 0, 0, 0, 0);
    checkOutput("rst_pre_req", pk(1, 1, 0, 0, 0, 0));
    aresetn = 1'b0;
    applyStimulus(0, 2'b01, 0, 0, 0, 0);
    checkOutput("rst_mid", pk(0, 0, 0, 0, 0, 0));
    aresetn = 1'b1;
    applyStimulus(0, 2'b01, 0, 0, 1, 1);
    checkOutput("rst_exit0", pk(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 0, 0, 1, 0);
    checkOutput("rst_exit1", pk(0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
